// File: rtl/pcap_ctrl_pkg.sv
// rtl/pcap_ctrl_pkg.sv - shared types and helpers for the position-capture run control
package pcap_ctrl_pkg;

    // Run-control sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FLUSH  = 2'd3
    } pcap_state_e;

    // Completion codes reported through pcap_status_o and HEALTH
    typedef enum logic [2:0] {
        CODE_OK            = 3'd0,
        CODE_DISARMED      = 3'd1,
        CODE_TOO_CLOSE     = 3'd2,
        CODE_DMA_OVF       = 3'd3,
        CODE_FLUSH_TIMEOUT = 3'd4
    } pcap_code_e;

    // TRIG_EDGE encodings; value 3 behaves as rising
    localparam logic [1:0] TRIG_RISING     = 2'd0;
    localparam logic [1:0] TRIG_FALLING    = 2'd1;
    localparam logic [1:0] TRIG_BOTH       = 2'd2;
    localparam logic [1:0] TRIG_RISING_ALT = 2'd3;

    // True when the transition prev -> cur matches the selected edge type
    function automatic logic edge_match(input logic [1:0] sel, input logic prev, input logic cur);
        logic hit;
        case (sel)
            TRIG_FALLING: hit = prev & ~cur;
            TRIG_BOTH:    hit = prev ^ cur;
            default:      hit = ~prev & cur;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pcap_edge_detect.sv
// rtl/pcap_edge_detect.sv - registered trigger edge detector with load and edge select
module pcap_edge_detect
    import pcap_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [1:0] sel_i,
    input  logic       sig_i,
    output logic       edge_o
);

    logic prev_q;

    // History register only tracks the input while detecting or when explicitly loaded,
    // so a level that changed while the detector was idle never looks like an edge.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            prev_q <= 1'b0;
        end else if (load_i || en_i) begin
            prev_q <= sig_i;
        end
    end

    // Edge qualification against the stored history
    always_comb begin
        edge_o = en_i & edge_match(sel_i, prev_q, sig_i);
    end

endmodule

// File: rtl/pcap_arm_ctrl.sv
// rtl/pcap_arm_ctrl.sv - arm/disarm run-control sequencer for the position-capture datapath
module pcap_arm_ctrl
    import pcap_ctrl_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int FLUSH_TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ARM,
    input  logic             DISARM,
    input  logic [1:0]       TRIG_EDGE,
    input  logic [CNT_W-1:0] MAX_CAPTURE,
    input  logic             enable_i,
    input  logic             trig_i,
    input  logic             dma_full_i,
    input  logic             frame_err_i,
    input  logic             drain_idle_i,
    output logic             trig_pulse_o,
    output logic             pcap_actv_o,
    output logic             pcap_start_o,
    output logic             pcap_done_o,
    output logic [2:0]       pcap_status_o,
    output logic [CNT_W-1:0] capture_cnt_o,
    output logic [31:0]      HEALTH
);

    localparam int              FW          = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [FW-1:0]   FLUSH_LIMIT = FW'(FLUSH_TIMEOUT);

    pcap_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pcap_code_e       status_q, status_d;
    pcap_code_e       health_q, health_d;
    logic             trig_q, trig_d;
    logic [FW-1:0]    flush_cnt_q, flush_cnt_d;

    logic             edge_load;
    logic             edge_en;
    logic             edge_hit;
    logic             start_pulse;
    logic             done_pulse;
    logic [CNT_W-1:0] cnt_inc;
    logic             max_hit;
    logic             end_hit;
    pcap_code_e       end_code;
    pcap_code_e       final_code;

    assign edge_en = (state_q == ST_ACTIVE);

    pcap_edge_detect u_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (edge_load),
        .en_i    (edge_en),
        .sel_i   (TRIG_EDGE),
        .sig_i   (trig_i),
        .edge_o  (edge_hit)
    );

    // Saturating increment and the count-limit test for the trigger being issued now
    always_comb begin
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        max_hit = (MAX_CAPTURE != '0) && (cnt_inc == MAX_CAPTURE);
    end

    // End-of-run arbitration while ACTIVE: DMA overflow beats frame error beats
    // DISARM beats the normal completions (enable dropped or count limit reached).
    always_comb begin
        end_hit  = 1'b1;
        end_code = CODE_OK;
        if (dma_full_i) begin
            end_code = CODE_DMA_OVF;
        end else if (frame_err_i) begin
            end_code = CODE_TOO_CLOSE;
        end else if (DISARM) begin
            end_code = CODE_DISARMED;
        end else if (!enable_i || (edge_hit && max_hit)) begin
            end_code = CODE_OK;
        end else begin
            end_hit = 1'b0;
        end
    end

    // A drained pipeline keeps the latched code; a timeout only replaces a clean code
    always_comb begin
        if (!drain_idle_i && (status_q == CODE_OK)) begin
            final_code = CODE_FLUSH_TIMEOUT;
        end else begin
            final_code = status_q;
        end
    end

    // Next-state and strobe generation for the run-control sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        status_d    = status_q;
        health_d    = health_q;
        trig_d      = 1'b0;
        flush_cnt_d = flush_cnt_q;
        edge_load   = 1'b0;
        start_pulse = 1'b0;
        done_pulse  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ARM) begin
                    state_d  = ST_ARMED;
                    cnt_d    = '0;
                    status_d = CODE_OK;
                    health_d = CODE_OK;
                end
            end
            ST_ARMED: begin
                if (DISARM) begin
                    state_d     = ST_FLUSH;
                    status_d    = CODE_DISARMED;
                    flush_cnt_d = '0;
                end else if (enable_i) begin
                    state_d     = ST_ACTIVE;
                    start_pulse = 1'b1;
                    edge_load   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // An edge seen in the same cycle as an end condition is still issued
                if (edge_hit) begin
                    trig_d = 1'b1;
                    cnt_d  = cnt_inc;
                end
                if (end_hit) begin
                    state_d     = ST_FLUSH;
                    status_d    = end_code;
                    flush_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                if (drain_idle_i || (flush_cnt_q == FLUSH_LIMIT)) begin
                    state_d    = ST_IDLE;
                    done_pulse = 1'b1;
                    status_d   = final_code;
                    health_d   = final_code;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and run bookkeeping registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            status_q    <= CODE_OK;
            health_q    <= CODE_OK;
            trig_q      <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            status_q    <= status_d;
            health_q    <= health_d;
            trig_q      <= trig_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign trig_pulse_o  = trig_q;
    assign pcap_actv_o   = (state_q != ST_IDLE);
    assign pcap_start_o  = start_pulse;
    assign pcap_done_o   = done_pulse;
    assign pcap_status_o = status_q;
    assign capture_cnt_o = cnt_q;
    assign HEALTH        = {29'b0, health_q};

endmodule
